a_rom_ctrl: RTL
===============

A_ROM_CTRL -- requirements
Module: a_rom_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 14, coefficient word width.
REQ-002 SHALL have parameter DEPTH, default 16, number of coefficient words; the address width AW = log2(DEPTH) = 4.
REQ-003 SHALL have parameter COLS, default 4, coefficients per row; ROWS = DEPTH/COLS.
REQ-004 SHALL have parameter NVEC, default 4, number of input vectors processed per run.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port load_start, input, 1 bit: pulse that requests a full coefficient reload.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-009 SHALL have port in_data, input, WIDTH bits: coefficient word from the upstream source.
REQ-010 SHALL have port in_ready, output, 1 bit: the controller accepts in_data this cycle.
REQ-011 SHALL have port w_en, output, 1 bit: coefficient memory write strobe.
REQ-012 SHALL have port w_addr, output, AW bits: coefficient memory write address.
REQ-013 SHALL have port dataROM, output, WIDTH bits: coefficient memory write data.
REQ-014 SHALL have port start, input, 1 bit: pulse that requests a compute run.
REQ-015 SHALL have port rom_addr, output, AW bits: coefficient memory read address (memory read is combinational).
REQ-016 SHALL have port rd_valid, output, 1 bit: rom_addr selects a live coefficient this cycle.
REQ-017 SHALL have port row_first, output, 1 bit: the current coefficient is column 0 (clear the accumulator).
REQ-018 SHALL have port row_last, output, 1 bit: the current coefficient is column COLS-1 (the row result is complete).
REQ-019 SHALL have port vec_idx, output, log2(NVEC) bits: index of the input vector being processed.
REQ-020 SHALL have port loaded, output, 1 bit: all DEPTH words have been written since the last reset or reload.
REQ-021 SHALL have port busy, output, 1 bit: the FSM is in LOAD or RUN.
REQ-022 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a run.

Function
REQ-023 SHALL implement the FSM states IDLE, LOAD and RUN; all outputs SHALL be registered except in_ready.
REQ-024 In IDLE, load_start=1 SHALL transition to LOAD, clear loaded and reset the write counter to 0.
REQ-025 In IDLE, start=1 with loaded=1 SHALL transition to RUN with row, col and vec counters at 0; start with loaded=0 SHALL be ignored.
REQ-026 If load_start and start are asserted in the same IDLE cycle, load SHALL win and start SHALL be dropped.
REQ-027 In LOAD, in_ready SHALL be 1 and a transfer SHALL occur on in_valid && in_ready.
REQ-028 On each LOAD transfer, the next cycle SHALL present w_en=1, w_addr=the write count and dataROM=in_data, and the write count SHALL increment.
REQ-029 w_en SHALL be 0 in every cycle without a transfer on the previous edge; w_addr and dataROM SHALL hold their last values.
REQ-030 in_valid=0 during LOAD SHALL stall the load with no timeout.
REQ-031 The transfer at write count DEPTH-1 SHALL return the FSM to IDLE and set loaded=1 on the following cycle, concurrent with the final w_en.
REQ-032 In RUN, each cycle SHALL present rd_valid=1, rom_addr = row*COLS + col, vec_idx = vec, row_first = (col==0) and row_last = (col==COLS-1).
REQ-033 In RUN, col SHALL wrap from COLS-1 to 0 and increment row; row SHALL wrap from ROWS-1 to 0 and increment vec.
REQ-034 The RUN cycle with col=COLS-1, row=ROWS-1 and vec=NVEC-1 SHALL be followed by done=1 for exactly one cycle and a return to IDLE with rd_valid=0.
REQ-035 A run SHALL last exactly DEPTH*NVEC cycles (64 by default), with the first rd_valid in the cycle after start is sampled.
REQ-036 load_start and start SHALL be ignored during LOAD and RUN.
REQ-037 in_ready, w_en and rd_valid SHALL be 0 outside their own states.
REQ-038 rom_addr SHALL hold its last value when idle.
REQ-039 busy SHALL be 1 in LOAD or RUN and 0 otherwise.

Reset
REQ-040 When rst=1 at a clock edge, the block SHALL go to IDLE and clear all counters.
REQ-041 Reset SHALL drive in_ready=0, w_en=0, w_addr=0, dataROM=0, rom_addr=0, rd_valid=0, row_first=0, row_last=0, vec_idx=0, loaded=0, busy=0 and done=0.
REQ-042 Reset mid-LOAD or mid-RUN SHALL abort the operation with no further w_en, rd_valid or done, and SHALL leave loaded=0.

Verification
REQ-043 Full load: load_start, then 16 back-to-back words 0x100+i -> w_en on 16 consecutive cycles, w_addr 0..15, dataROM 0x100..0x10F, loaded=1 after the last write, busy falls.
REQ-044 Stalled load: in_valid toggles 1,0,0,1,... -> one write per accepted word, w_addr sequence gapless 0..15, w_en=0 in stall cycles.
REQ-045 Run: after load, pulse start -> 64 rd_valid cycles, rom_addr 0..15 repeated 4 times, row_first at addresses 0,4,8,12, row_last at 3,7,11,15, vec_idx 0..3, then a single done pulse.
REQ-046 Illegal requests: start with loaded=0 -> no activity; load_start during RUN -> ignored, run completes; simultaneous load_start+start in IDLE -> LOAD entered.
REQ-047 Reset abort: rst at load word 7 -> loaded=0, w_en=0; rst at run cycle 20 -> rd_valid=0, no done, IDLE.

Source files
------------

// File: rtl/a_rom_ctrl.sv
// a_rom_ctrl -- coefficient memory controller.
//
// Loads DEPTH coefficient words from an upstream valid/ready source into an
// external coefficient memory. Then, on request, sweeps the memory read
// address row by row, NVEC times: once per input vector.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   load_start      pulse: reload all DEPTH words (accepted in IDLE only)
//   in_valid/in_data/in_ready
//                   upstream coefficient stream; in_ready is the only
//                   combinational output
//   w_en/w_addr/dataROM
//                   memory write port, registered one cycle after a transfer
//   start           pulse: start a compute run (accepted in IDLE with loaded=1)
//   rom_addr        memory read address; memory read is combinational
//   rd_valid        rom_addr selects a live coefficient this cycle
//   row_first       current coefficient is column 0 (clear the accumulator)
//   row_last        current coefficient is column COLS-1 (row result done)
//   vec_idx         input vector currently being processed
//   loaded          all DEPTH words written since the last reset or reload
//   busy            controller is in LOAD or RUN
//   done            one-cycle pulse after the final read of a run
module a_rom_ctrl #(
  parameter  int WIDTH = 14,
  parameter  int DEPTH = 16,
  parameter  int COLS  = 4,
  parameter  int NVEC  = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int VW    = (NVEC  > 1) ? $clog2(NVEC)  : 1
) (
  input  logic             clk,
  input  logic             rst,
  // load side
  input  logic             load_start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             w_en,
  output logic [AW-1:0]    w_addr,
  output logic [WIDTH-1:0] dataROM,
  // run side
  input  logic             start,
  output logic [AW-1:0]    rom_addr,
  output logic             rd_valid,
  output logic             row_first,
  output logic             row_last,
  output logic [VW-1:0]    vec_idx,
  // status
  output logic             loaded,
  output logic             busy,
  output logic             done
);

  localparam int ROWS = DEPTH / COLS;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [AW-1:0]    wcnt_q, wcnt_d;     // next memory word to write
  logic [CW-1:0]    col_q, col_d;       // position of the coefficient
  logic [RW-1:0]    row_q, row_d;       //   currently presented on
  logic [VW-1:0]    vec_q, vec_d;       //   rom_addr

  // Registered outputs
  logic             w_en_q, w_en_d;
  logic [AW-1:0]    w_addr_q, w_addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AW-1:0]    rom_addr_q, rom_addr_d;
  logic             rd_valid_q, rd_valid_d;
  logic             row_first_q, row_first_d;
  logic             row_last_q, row_last_d;
  logic [VW-1:0]    vec_idx_q, vec_idx_d;
  logic             loaded_q, loaded_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Position flags of the coefficient presented this cycle
  logic col_end, row_end, vec_end, run_end;

  assign col_end = (col_q == CW'(COLS - 1));
  assign row_end = (row_q == RW'(ROWS - 1));
  assign vec_end = (vec_q == VW'(NVEC - 1));
  assign run_end = col_end && row_end && vec_end;

  // Ready depends only on the current state so the upstream sees it in the
  // same cycle it must decide whether to hold its word.
  assign in_ready = (state_q == S_LOAD);

  // ---------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    col_d       = col_q;
    row_d       = row_q;
    vec_d       = vec_q;
    loaded_d    = loaded_q;
    w_en_d      = 1'b0;
    w_addr_d    = w_addr_q;
    data_d      = data_q;
    rd_valid_d  = 1'b0;
    rom_addr_d  = rom_addr_q;
    row_first_d = 1'b0;
    row_last_d  = 1'b0;
    vec_idx_d   = vec_idx_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Load has priority: a simultaneous start is dropped.
        if (load_start) begin
          state_d  = S_LOAD;
          loaded_d = 1'b0;
          wcnt_d   = '0;
        end else if (start && loaded_q) begin
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
          vec_d   = '0;
        end
      end

      S_LOAD: begin
        // in_ready is 1 throughout LOAD, so in_valid alone is a transfer.
        if (in_valid) begin
          w_en_d   = 1'b1;
          w_addr_d = wcnt_q;
          data_d   = in_data;
          wcnt_d   = wcnt_q + AW'(1);
          if (wcnt_q == AW'(DEPTH - 1)) begin
            state_d  = S_IDLE;
            loaded_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (run_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (col_end) begin
          col_d = '0;
          if (row_end) begin
            row_d = '0;
            vec_d = vec_q + VW'(1);
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // The read-side outputs describe the position the counters will hold
    // next cycle, so entering RUN presents coefficient 0 on the first
    // cycle after start is sampled.
    if (state_d == S_RUN) begin
      rd_valid_d  = 1'b1;
      rom_addr_d  = AW'(int'(row_d) * COLS + int'(col_d));
      row_first_d = (col_d == '0);
      row_last_d  = (col_d == CW'(COLS - 1));
      vec_idx_d   = vec_d;
    end

    busy_d = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      vec_q       <= '0;
      w_en_q      <= 1'b0;
      w_addr_q    <= '0;
      data_q      <= '0;
      rom_addr_q  <= '0;
      rd_valid_q  <= 1'b0;
      row_first_q <= 1'b0;
      row_last_q  <= 1'b0;
      vec_idx_q   <= '0;
      loaded_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      vec_q       <= vec_d;
      w_en_q      <= w_en_d;
      w_addr_q    <= w_addr_d;
      data_q      <= data_d;
      rom_addr_q  <= rom_addr_d;
      rd_valid_q  <= rd_valid_d;
      row_first_q <= row_first_d;
      row_last_q  <= row_last_d;
      vec_idx_q   <= vec_idx_d;
      loaded_q    <= loaded_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign w_en      = w_en_q;
  assign w_addr    = w_addr_q;
  assign dataROM   = data_q;
  assign rom_addr  = rom_addr_q;
  assign rd_valid  = rd_valid_q;
  assign row_first = row_first_q;
  assign row_last  = row_last_q;
  assign vec_idx   = vec_idx_q;
  assign loaded    = loaded_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
